// File: rtl/dram_cmd_sequencer_pkg.sv
// dram_cmd_sequencer_pkg
// Shared definitions for the DRAM command sequencer: FSM state encoding and
// the default refresh schedule.
package dram_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    REFRESH = 2'd3
  } state_t;

  localparam int DEF_REFRESH_INTERVAL = 64;
  localparam int DEF_REFRESH_CYCLES   = 2;

  // Width of a down-counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer
// Free-running refresh interval counter. Counts REFRESH_INTERVAL-1 down to 0
// and reloads; each expiry raises a pending flag that the sequencer clears
// when it starts the refresh burst. An expiry while the flag is still set
// latches a sticky overrun error that only reset clears.
// Ports:
//   Clock         - rising-edge clock
//   nReset        - asynchronous active-low reset
//   i_pending_clr - sequencer is starting the refresh burst this cycle
//   o_pending     - a refresh is owed to the array
//   o_overrun     - sticky: an interval expired with a refresh still owed
module dram_refresh_timer
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic Clock,
  input  logic nReset,
  input  logic i_pending_clr,
  output logic o_pending,
  output logic o_overrun
);

  localparam int TW = cnt_width(REFRESH_INTERVAL);
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] r_timer;
  logic          r_pending;
  logic          r_overrun;
  logic          w_expire;

  assign w_expire = (r_timer == '0);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_timer   <= RELOAD;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_timer <= w_expire ? RELOAD : r_timer - 1'b1;
      // A fresh expiry outranks a same-cycle clear: the new interval still
      // owes the array a refresh.
      if (w_expire) begin
        r_pending <= 1'b1;
        if (r_pending) r_overrun <= 1'b1;
      end else if (i_pending_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer
// Converts single-word host read/write requests (valid/ready) into the DRAM
// array's Enable/Read/Write/Address/data strobes and inserts periodic
// refresh bursts, which always win over host traffic.
// Ports:
//   Clock, nReset            - clock, asynchronous active-low reset
//   ReqValid/ReqReady        - host request handshake
//   ReqWrite, ReqAddress,
//   ReqWriteData             - request kind, address, write word
//   RespValid, RespReadData  - one-cycle read-data pulse, data held after
//   Enable, Read, Write,
//   Refresh, Address         - registered array controls
//   DataOut, DataOutEnable   - write word and bus-drive enable
//   DataIn                   - array read data
//   RefreshOverrun           - sticky refresh-schedule error
module dram_cmd_sequencer
  import dram_cmd_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH       = 1,
  parameter int DATA_WIDTH       = 1,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int REFRESH_CYCLES   = DEF_REFRESH_CYCLES
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqWriteData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] RespReadData,
  output logic                  Enable,
  output logic                  Read,
  output logic                  Write,
  output logic                  Refresh,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataOutEnable,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  RefreshOverrun
);

  localparam int BW = cnt_width(REFRESH_CYCLES);
  localparam logic [BW-1:0] BURST_LOAD = BW'(REFRESH_CYCLES - 1);

  state_t                r_state;
  logic [BW-1:0]         r_burst;
  logic                  r_enable;
  logic                  r_read;
  logic                  r_write;
  logic                  r_refresh;
  logic                  r_doe;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;

  logic w_pending;
  logic w_overrun;
  logic w_pending_clr;

  // The refresh is taken exactly when IDLE sees the pending flag.
  assign w_pending_clr = (r_state == IDLE) && w_pending;

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .Clock         (Clock),
    .nReset        (nReset),
    .i_pending_clr (w_pending_clr),
    .o_pending     (w_pending),
    .o_overrun     (w_overrun)
  );

  // Ready only from registered state, so the host sees no combinational path.
  assign ReqReady = (r_state == IDLE) && !w_pending;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state      <= IDLE;
      r_burst      <= '0;
      r_enable     <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_refresh    <= 1'b0;
      r_doe        <= 1'b0;
      r_address    <= '0;
      r_dout       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_state   <= REFRESH;
            r_refresh <= 1'b1;
            r_burst   <= BURST_LOAD;
          end else if (ReqValid) begin
            // Strobes are set on entry so they are registered during ACCESS;
            // r_write doubles as the latched request kind.
            r_state   <= ACCESS;
            r_enable  <= 1'b1;
            r_write   <= ReqWrite;
            r_read    <= !ReqWrite;
            r_doe     <= ReqWrite;
            r_address <= ReqAddress;
            r_dout    <= ReqWriteData;
          end
        end
        ACCESS: begin
          r_enable <= 1'b0;
          r_read   <= 1'b0;
          r_write  <= 1'b0;
          r_doe    <= 1'b0;
          if (r_read) begin
            // DataIn is taken while Read is still asserted, so the registered
            // response is visible throughout the CAPTURE cycle.
            r_resp_valid <= 1'b1;
            r_resp_data  <= DataIn;
            r_state      <= CAPTURE;
          end else begin
            r_state <= IDLE;
          end
        end
        CAPTURE: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
        REFRESH: begin
          if (r_burst == '0) begin
            r_refresh <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_burst <= r_burst - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Enable         = r_enable;
  assign Read           = r_read;
  assign Write          = r_write;
  assign Refresh        = r_refresh;
  assign Address        = r_address;
  assign DataOut        = r_dout;
  assign DataOutEnable  = r_doe;
  assign RespValid      = r_resp_valid;
  assign RespReadData   = r_resp_data;
  assign RefreshOverrun = w_overrun;

endmodule
